// File: rtl/frogger_state_ctrl.sv
// frogger_state_ctrl
// Top-level game sequencer for the Frogger datapath. Tracks the game phase
// and the lives counter. Gates the frog controller with o_Game_Active,
// requests frog respawn and score clear, and freezes play during the
// post-collision hold. All outputs decode registered state only.
module frogger_state_ctrl #(
    parameter int         c_LIVES        = 3,
    parameter logic [6:0] c_WIN_SCORE    = 7'd10,
    parameter int         c_HOLD_CYCLES  = 25000000,
    parameter int         c_GRACE_CYCLES = 4
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Game_Start,
    input  logic       i_Collided,
    input  logic [6:0] i_Score,
    output logic [2:0] o_State,
    output logic       o_Game_Active,
    output logic       o_Hit_Freeze,
    output logic [1:0] o_Lives,
    output logic       o_Frogger_Reset,
    output logic       o_Score_Clear,
    output logic       o_Game_Over
);

    localparam int c_HOLD_W  = (c_HOLD_CYCLES > 1) ? $clog2(c_HOLD_CYCLES) : 1;
    localparam int c_GRACE_W = (c_GRACE_CYCLES > 0) ? $clog2(c_GRACE_CYCLES + 1) : 1;

    localparam logic [c_HOLD_W-1:0]  c_HOLD_LAST  = c_HOLD_W'(c_HOLD_CYCLES - 1);
    localparam logic [c_HOLD_W-1:0]  c_HOLD_ONE   = c_HOLD_W'(1);
    localparam logic [c_GRACE_W-1:0] c_GRACE_LOAD = c_GRACE_W'(c_GRACE_CYCLES);
    localparam logic [c_GRACE_W-1:0] c_GRACE_ONE  = c_GRACE_W'(1);
    localparam logic [1:0]           c_LIVES_LOAD = 2'(c_LIVES);

    // Encoding is visible on o_State, so the values are fixed explicitly.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RUNNING   = 3'd1,
        ST_P1_WINS   = 3'd2,
        ST_CLEANUP   = 3'd3,
        ST_HIT       = 3'd4,
        ST_GAME_OVER = 3'd5
    } state_t;

    state_t               r_State;
    logic                 r_Start_Prev;
    logic [1:0]           r_Lives;
    logic [c_HOLD_W-1:0]  r_Hold_Cnt;
    logic [c_GRACE_W-1:0] r_Grace_Cnt;

    state_t               w_Next_State;
    logic [1:0]           w_Next_Lives;
    logic [c_HOLD_W-1:0]  w_Next_Hold;
    logic [c_GRACE_W-1:0] w_Next_Grace;
    logic                 w_Start_Edge;
    logic                 w_Hold_Done;

    assign w_Start_Edge = i_Game_Start & ~r_Start_Prev;
    assign w_Hold_Done  = (r_Hold_Cnt == c_HOLD_LAST);

    // Register the game phase, counters and the start-button history.
    // r_Start_Prev resets high so a button held through reset is not an edge.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_State      <= ST_IDLE;
            r_Start_Prev <= 1'b1;
            r_Lives      <= c_LIVES_LOAD;
            r_Hold_Cnt   <= '0;
            r_Grace_Cnt  <= '0;
        end else begin
            r_State      <= w_Next_State;
            r_Start_Prev <= i_Game_Start;
            r_Lives      <= w_Next_Lives;
            r_Hold_Cnt   <= w_Next_Hold;
            r_Grace_Cnt  <= w_Next_Grace;
        end
    end

    // Next-state and counter update. Lives and grace are loaded both on
    // entry to CLEANUP and during it, so o_Lives already shows the fresh
    // count while the clear pulses are out.
    always_comb begin
        w_Next_State = r_State;
        w_Next_Lives = r_Lives;
        w_Next_Hold  = r_Hold_Cnt;
        w_Next_Grace = r_Grace_Cnt;

        case (r_State)
            ST_IDLE, ST_P1_WINS, ST_GAME_OVER: begin
                if (w_Start_Edge) begin
                    w_Next_State = ST_CLEANUP;
                    w_Next_Lives = c_LIVES_LOAD;
                    w_Next_Grace = c_GRACE_LOAD;
                end
            end

            ST_CLEANUP: begin
                w_Next_State = ST_RUNNING;
                w_Next_Lives = c_LIVES_LOAD;
                w_Next_Grace = c_GRACE_LOAD;
            end

            ST_RUNNING: begin
                if (r_Grace_Cnt != '0) begin
                    w_Next_Grace = r_Grace_Cnt - c_GRACE_ONE;
                end
                if ((r_Grace_Cnt == '0) && i_Collided) begin
                    w_Next_State = ST_HIT;
                    w_Next_Hold  = '0;
                    if (r_Lives != 2'd0) begin
                        w_Next_Lives = r_Lives - 2'd1;
                    end
                end else if (i_Score >= c_WIN_SCORE) begin
                    w_Next_State = ST_P1_WINS;
                end
            end

            ST_HIT: begin
                w_Next_Hold = r_Hold_Cnt + c_HOLD_ONE;
                if (w_Hold_Done) begin
                    w_Next_Hold = '0;
                    if (r_Lives != 2'd0) begin
                        w_Next_State = ST_RUNNING;
                        w_Next_Grace = c_GRACE_LOAD;
                    end else begin
                        w_Next_State = ST_GAME_OVER;
                    end
                end
            end

            default: begin
                w_Next_State = ST_IDLE;
            end
        endcase
    end

    assign o_State         = r_State;
    assign o_Lives         = r_Lives;
    assign o_Game_Active   = (r_State == ST_RUNNING);
    assign o_Hit_Freeze    = (r_State == ST_HIT);
    assign o_Game_Over     = (r_State == ST_GAME_OVER);
    assign o_Score_Clear   = (r_State == ST_CLEANUP);
    assign o_Frogger_Reset = (r_State == ST_CLEANUP) |
                             ((r_State == ST_HIT) && w_Hold_Done && (r_Lives != 2'd0));

endmodule

// File: doc/frogger_state_ctrl.md
# frogger_state_ctrl

Top-level game sequencer for the Frogger datapath. Owns the game state (IDLE, CLEANUP, RUNNING, HIT, P1_WINS, GAME_OVER) and the lives counter. Drives the `i_Game_Active` enable into the frog controller, the frog respawn and score-clear requests, and a freeze during the post-collision hold. Consumes the collision flag and the score from the existing blocks.

## Interface
- `c_LIVES`, 3: lives loaded at game start; range 1–3.
- `c_WIN_SCORE`, 7'd10: score at or above which player 1 wins.
- `c_HOLD_CYCLES`, 25000000: length of the HIT hold in clocks; must be ≥ 2.
- `c_GRACE_CYCLES`, 4: clocks after entering RUNNING during which `i_Collided` is ignored; must be ≥ 1.

Ports:
- `i_Clk`, in, 1: system clock.
- `i_Rst`, in, 1: synchronous, active-high reset.
- `i_Game_Start`, in, 1: start button level, already debounced.
- `i_Collided`, in, 1: collision flag from the collision block (level).
- `i_Score`, in, 7: current score.
- `o_State`, out, 3: state code. IDLE=0, RUNNING=1, P1_WINS=2, CLEANUP=3, HIT=4, GAME_OVER=5.
- `o_Game_Active`, out, 1: high only in RUNNING.
- `o_Hit_Freeze`, out, 1: high only in HIT.
- `o_Lives`, out, 2: remaining lives.
- `o_Frogger_Reset`, out, 1: one-cycle request to return the frog to its start tile.
- `o_Score_Clear`, out, 1: one-cycle request to zero the score.
- `o_Game_Over`, out, 1: high only in GAME_OVER.

## Operation
- **Start edge.** `r_Start_Prev` registers `i_Game_Start` every cycle. The start edge is `i_Game_Start & ~r_Start_Prev`. Reset loads `r_Start_Prev`=1, so a button held through reset produces no edge until it is released and pressed again.
- **IDLE.**
  - Start edge → CLEANUP.
  - All other inputs are ignored.
- **CLEANUP.** Lasts exactly one cycle.
  - `o_Score_Clear`=1 and `o_Frogger_Reset`=1.
  - Lives load `c_LIVES`.
  - Grace counter loads `c_GRACE_CYCLES`.
  - Next state is RUNNING, unconditionally.
- **RUNNING.**
  - The grace counter decrements to 0 and saturates there.
  - If grace = 0 and `i_Collided`=1 → HIT. Lives decrement by 1, saturating at 0, and the hold counter clears to 0.
  - Else if `i_Score` ≥ `c_WIN_SCORE` → P1_WINS.
  - Collision has priority over win when both occur in the same cycle.
  - The start edge is ignored in RUNNING.
- **HIT.**
  - The hold counter increments every cycle. `i_Collided`, `i_Score` and the start edge are ignored.
  - When the counter reaches `c_HOLD_CYCLES`−1 and lives ≠ 0: `o_Frogger_Reset`=1 in that cycle, the grace counter loads `c_GRACE_CYCLES`, and the next state is RUNNING.
  - When the counter reaches `c_HOLD_CYCLES`−1 and lives = 0: the next state is GAME_OVER and no frog reset is issued.
- **P1_WINS, GAME_OVER.**
  - Hold until a start edge, then → CLEANUP.
  - Lives are unchanged while holding.
- **Illegal state codes (6, 7)** → IDLE on the next clock.
- **Width rules.**
  - Lives: 2-bit, saturating decrement.
  - Hold counter: $clog2(`c_HOLD_CYCLES`) bits.
  - Grace counter: $clog2(`c_GRACE_CYCLES`+1) bits.
  - Score compare: 7-bit unsigned.

## Timing
- **Reset values.** State=IDLE, `o_Lives`=`c_LIVES`, both counters 0, and `o_Game_Active`, `o_Hit_Freeze`, `o_Frogger_Reset`, `o_Score_Clear`, `o_Game_Over` all 0.
- **Reset priority.** Reset mid-game (any state, any counter value) returns to IDLE on the next edge. Any pulse in flight is dropped.
- **Output timing.** All outputs are Moore decodes of registered state plus the registered counters; there is no input-to-output combinational path.
- **Start latency.** Start edge sampled at clock edge N → CLEANUP at edge N → pulses visible during cycle N..N+1 → RUNNING at edge N+1.
- **Collision latency.** `i_Collided` sampled at edge M with grace 0 → HIT and lives−1 at edge M. `o_Game_Active` falls in the same cycle.
- **HIT duration.** Exactly `c_HOLD_CYCLES` cycles in HIT. `o_Frogger_Reset` is asserted in the last of them. RUNNING resumes on the following edge.
- **Collision after respawn.** `i_Collided` held high continuously after respawn causes the next HIT exactly `c_GRACE_CYCLES`+1 cycles after entering RUNNING.
- **Win latency.** Win detection has 1-edge latency from `i_Score` reaching `c_WIN_SCORE`.

## Test plan
Bench parameters: `c_LIVES`=3, `c_WIN_SCORE`=5, `c_HOLD_CYCLES`=8, `c_GRACE_CYCLES`=2.

1. **Reset and start.** Assert `i_Rst` 2 cycles with button high, release, keep button high 5 cycles → state stays IDLE. Drop the button, raise it → CLEANUP for exactly 1 cycle with `o_Score_Clear`=`o_Frogger_Reset`=1 and `o_Lives`=3, then RUNNING with `o_Game_Active`=1.
2. **Single hit.** In RUNNING after grace, pulse `i_Collided` for 1 cycle → HIT on the next edge, `o_Lives`=2, `o_Hit_Freeze` high for 8 cycles, `o_Frogger_Reset` high only in the 8th, then RUNNING.
3. **Game over.** Hold `i_Collided`=1 permanently from RUNNING → HIT entries spaced 3 cycles after each RUNNING entry, lives go 3→2→1→0. After the third hold: GAME_OVER with `o_Game_Over`=1, no reset pulse, `o_Lives`=0.
4. **Win, and collision priority.**
   - Drive `i_Score`=5 in RUNNING with no collision → P1_WINS, and `o_Lives` is unchanged.
   - Separately, drive score 5 and a collision in the same cycle → HIT, not P1_WINS.
5. **Restart from an end state.** From GAME_OVER or P1_WINS, give a start edge → CLEANUP, `o_Score_Clear` pulse, lives reload to 3, RUNNING.
6. **Mid-operation reset.** Assert `i_Rst` in HIT with the hold counter at 4 → IDLE next edge, `o_Hit_Freeze`=0, `o_Lives`=3, no `o_Frogger_Reset` pulse.
